// File: rtl/read_data_if.sv
// MEM-stage load bus between the pipeline/memory side (master) and read_data (slave).
// Load op encodings fall back to the core's usual values when the core defines are absent.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b11100100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b11100001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b11100101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b11100011
`endif

interface read_data_if;
  logic [7:0]  alucontrolM;
  logic [31:0] aluoutM;
  logic        validM;
  logic        flushM;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [31:0] readdata_resultM;
  logic        load_done;
  logic        stallM;
  logic        adelM;

  modport master (
    output alucontrolM, aluoutM, validM, flushM, data_ack, data_rdata,
    input  data_req, data_addr, readdata_resultM, load_done, stallM, adelM
  );

  modport slave (
    input  alucontrolM, aluoutM, validM, flushM, data_ack, data_rdata,
    output data_req, data_addr, readdata_resultM, load_done, stallM, adelM
  );
endinterface

// File: rtl/read_data.sv
// Load unit: one word read per load, result registered on ack and flagged by load_done next cycle.
// stallM holds the pipeline until ack; READ_DATA_ADEL_EN traps misaligned LW/LH/LHU on adelM.
module read_data (
  input  logic       clk,
  input  logic       resetn,
  read_data_if.slave rd
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_result;

  logic        w_is_lw, w_is_half, w_is_byte, w_is_load;
  logic        w_start, w_capture;
  logic        w_req, w_stall, w_done;
  logic [1:0]  w_off, w_sel_off;
  logic [7:0]  w_op;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_extract;

  assign w_is_lw   = (rd.alucontrolM == `EXE_LW_OP);
  assign w_is_half = (rd.alucontrolM == `EXE_LH_OP) | (rd.alucontrolM == `EXE_LHU_OP);
  assign w_is_byte = (rd.alucontrolM == `EXE_LB_OP) | (rd.alucontrolM == `EXE_LBU_OP);
  assign w_is_load = w_is_lw | w_is_half | w_is_byte;

  // Offset bits a wider load cannot use are forced low, so a misaligned access reads its own word.
  assign w_off = {rd.aluoutM[1] & ~w_is_lw, rd.aluoutM[0] & w_is_byte};

`ifdef READ_DATA_ADEL_EN
  logic w_misaligned;
  assign w_misaligned = (w_is_lw & |rd.aluoutM[1:0]) | (w_is_half & rd.aluoutM[0]);
  assign w_start      = rd.validM & w_is_load & ~rd.flushM & ~w_misaligned;
  assign rd.adelM     = resetn & rd.validM & w_is_load & w_misaligned;
`else
  assign w_start  = rd.validM & w_is_load & ~rd.flushM;
  assign rd.adelM = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_done    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_req     = 1'b1;
          w_capture = rd.data_ack;
          w_stall   = ~rd.data_ack;
          w_next    = rd.data_ack ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (rd.data_ack) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (rd.flushM) begin
          w_next = DRAIN;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      DRAIN: begin
        w_stall = 1'b1;
        if (rd.data_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // An immediate ack in IDLE has not latched op/offset yet, so extract from the live inputs.
  assign w_op      = (r_state == IDLE) ? rd.alucontrolM : r_op;
  assign w_sel_off = (r_state == IDLE) ? w_off : r_off;
  assign w_half    = w_sel_off[1] ? rd.data_rdata[31:16] : rd.data_rdata[15:0];

  always_comb begin
    w_byte = rd.data_rdata[7:0];
    case (w_sel_off)
      2'b01:   w_byte = rd.data_rdata[15:8];
      2'b10:   w_byte = rd.data_rdata[23:16];
      2'b11:   w_byte = rd.data_rdata[31:24];
      default: w_byte = rd.data_rdata[7:0];
    endcase
  end

  always_comb begin
    w_extract = rd.data_rdata;
    case (w_op)
      `EXE_LH_OP:  w_extract = {{16{w_half[15]}}, w_half};
      `EXE_LHU_OP: w_extract = {16'h0000, w_half};
      `EXE_LB_OP:  w_extract = {{24{w_byte[7]}}, w_byte};
      `EXE_LBU_OP: w_extract = {24'h000000, w_byte};
      default:     w_extract = rd.data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_op     <= 8'h00;
      r_off    <= 2'b00;
      r_addr   <= 32'h0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_start) begin
        r_op   <= rd.alucontrolM;
        r_off  <= w_off;
        r_addr <= {rd.aluoutM[31:2], 2'b00};
      end
      if (w_capture) r_result <= w_extract;
    end
  end

  assign rd.data_req         = resetn & w_req;
  assign rd.stallM           = resetn & w_stall;
  assign rd.load_done        = resetn & w_done;
  assign rd.data_addr        = (r_state == IDLE) ? {rd.aluoutM[31:2], 2'b00} : r_addr;
  assign rd.readdata_resultM = r_result;

endmodule

// File: tb/tb_read_data.sv
// Bench for read_data: table of load vectors plus hand sequences for flush, misalignment,
// back-to-back loads and reset mid-access; load results are checked through a scoreboard queue.
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b11100100
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b11100001
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b11100101
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b11100011
`endif

module tb_read_data;
  localparam logic [7:0] OP_ADD = 8'b00100000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  read_data_if bus();
  read_data dut (.clk(clk), .resetn(resetn), .rd(bus));

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic [31:0] last_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every load_done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.load_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load_done", 32'(bus.load_done), 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", bus.readdata_resultM, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.validM      = 1'b0;
    bus.alucontrolM = OP_ADD;
    bus.aluoutM     = 32'h0;
    bus.flushM      = 1'b0;
    bus.data_ack    = 1'b0;
    bus.data_rdata  = 32'h0;
  endtask

  task automatic run_load(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input int delay, input logic [31:0] exp);
    int          stalls;
    logic [31:0] exp_addr;
    stalls   = 0;
    exp_addr = {addr[31:2], 2'b00};
    step();
    bus.validM      = 1'b1;
    bus.alucontrolM = op;
    bus.aluoutM     = addr;
    bus.data_rdata  = rdata;
    bus.data_ack    = (delay == 0);
    #1;
    check("data_req", 32'(bus.data_req), 32'h1);
    check("data_addr", bus.data_addr, exp_addr);
    check("adelM_aligned", 32'(bus.adelM), 32'h0);
    if (bus.stallM) stalls++;
    exp_q.push_back(exp);
    for (int i = 1; i <= delay; i++) begin
      step();
      bus.aluoutM  = ~addr;
      bus.data_ack = (i == delay);
      #1;
      check("wait_addr_held", bus.data_addr, exp_addr);
      if (bus.stallM) stalls++;
    end
    step();
    drive_idle();
    #1;
    check("load_done", 32'(bus.load_done), 32'h1);
    check("done_no_stall", 32'(bus.stallM), 32'h0);
    check("stall_cycles", 32'(stalls), (delay == 0) ? 32'h0 : 32'(delay + 1));
    last_result = exp;
  endtask

  initial begin
    vecs[0] = '{`EXE_LB_OP,  32'h0000_0103, 32'h80FF_1234, 0, 32'hFFFF_FF80};
    vecs[1] = '{`EXE_LHU_OP, 32'h0000_0202, 32'h8001_7FFF, 2, 32'h0000_8001};
    vecs[2] = '{`EXE_LW_OP,  32'h0000_0004, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[3] = '{`EXE_LH_OP,  32'h0000_0010, 32'h1234_8765, 0, 32'hFFFF_8765};
    vecs[4] = '{`EXE_LH_OP,  32'h0000_0012, 32'h7FFF_0000, 3, 32'h0000_7FFF};
    vecs[5] = '{`EXE_LHU_OP, 32'h0000_0020, 32'h0000_F00D, 0, 32'h0000_F00D};
    vecs[6] = '{`EXE_LBU_OP, 32'h0000_0031, 32'h0000_AB00, 1, 32'h0000_00AB};
    vecs[7] = '{`EXE_LB_OP,  32'h0000_0042, 32'h007F_0000, 0, 32'h0000_007F};
    vecs[8] = '{`EXE_LB_OP,  32'h0000_0040, 32'h0000_00C3, 0, 32'hFFFF_FFC3};
    vecs[9] = '{`EXE_LBU_OP, 32'h0000_0053, 32'hFE00_0000, 2, 32'h0000_00FE};

    // Reset, with a live load presented to prove outputs stay quiet.
    drive_idle();
    resetn          = 1'b0;
    bus.validM      = 1'b1;
    bus.alucontrolM = `EXE_LW_OP;
    bus.aluoutM     = 32'h0000_0100;
    repeat (3) step();
    check("rst_data_req", 32'(bus.data_req), 32'h0);
    check("rst_load_done", 32'(bus.load_done), 32'h0);
    check("rst_stallM", 32'(bus.stallM), 32'h0);
    check("rst_adelM", 32'(bus.adelM), 32'h0);
    check("rst_result", bus.readdata_resultM, 32'h0);
    drive_idle();
    resetn = 1'b1;
    last_result = 32'h0;

    // Non-load op, and load without validM, and load under flush: nothing happens.
    step();
    bus.validM = 1'b1; bus.alucontrolM = OP_ADD; bus.aluoutM = 32'h100; #1;
    check("nonload_req", 32'(bus.data_req), 32'h0);
    check("nonload_stall", 32'(bus.stallM), 32'h0);
    step();
    bus.validM = 1'b0; bus.alucontrolM = `EXE_LW_OP; #1;
    check("novalid_req", 32'(bus.data_req), 32'h0);
    check("novalid_stall", 32'(bus.stallM), 32'h0);
    step();
    bus.validM = 1'b1; bus.flushM = 1'b1; #1;
    check("flush_idle_req", 32'(bus.data_req), 32'h0);
    check("flush_idle_stall", 32'(bus.stallM), 32'h0);
    drive_idle();

    for (int v = 0; v < 10; v++)
      run_load(vecs[v].op, vecs[v].addr, vecs[v].rdata, vecs[v].delay, vecs[v].exp);

    // Flush while waiting: drain the stale ack without a load_done.
    step();
    bus.validM = 1'b1; bus.alucontrolM = `EXE_LW_OP; bus.aluoutM = 32'h60; #1;
    check("fl_start_stall", 32'(bus.stallM), 32'h1);
    step();
    bus.flushM = 1'b1; bus.validM = 1'b0; #1;
    check("fl_wait_req", 32'(bus.data_req), 32'h1);
    step();
    bus.flushM = 1'b0; #1;
    check("fl_drain_req", 32'(bus.data_req), 32'h0);
    check("fl_drain_stall", 32'(bus.stallM), 32'h1);
    step();
    bus.data_ack = 1'b1; bus.data_rdata = 32'hBAD0_BAD0; #1;
    check("fl_ack_stall", 32'(bus.stallM), 32'h1);
    step();
    drive_idle(); #1;
    check("fl_no_done", 32'(bus.load_done), 32'h0);
    check("fl_stall_off", 32'(bus.stallM), 32'h0);
    check("fl_result_kept", bus.readdata_resultM, last_result);

    // Misaligned halfword.
`ifdef READ_DATA_ADEL_EN
    step();
    bus.validM = 1'b1; bus.alucontrolM = `EXE_LH_OP; bus.aluoutM = 32'h301; #1;
    check("adel_raised", 32'(bus.adelM), 32'h1);
    check("adel_no_req", 32'(bus.data_req), 32'h0);
    check("adel_no_stall", 32'(bus.stallM), 32'h0);
    step();
    drive_idle(); #1;
    check("adel_cleared", 32'(bus.adelM), 32'h0);
    check("adel_no_done", 32'(bus.load_done), 32'h0);
`else
    run_load(`EXE_LH_OP,  32'h0000_0301, 32'h1234_ABCD, 0, 32'hFFFF_ABCD);
    run_load(`EXE_LW_OP,  32'h0000_0302, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    run_load(`EXE_LHU_OP, 32'h0000_0303, 32'hAAAA_5555, 0, 32'h0000_AAAA);
`endif

    // Back-to-back byte loads, each acked immediately.
    step();
    bus.validM = 1'b1; bus.alucontrolM = `EXE_LB_OP; bus.aluoutM = 32'h0;
    bus.data_rdata = 32'h0000_81F0; bus.data_ack = 1'b1; #1;
    check("b2b_req0", 32'(bus.data_req), 32'h1);
    check("b2b_stall0", 32'(bus.stallM), 32'h0);
    exp_q.push_back(32'hFFFF_FFF0);
    step();
    bus.alucontrolM = `EXE_LBU_OP; bus.aluoutM = 32'h1; #1;
    check("b2b_done0", 32'(bus.load_done), 32'h1);
    check("b2b_no_req_in_done", 32'(bus.data_req), 32'h0);
    step();
    check("b2b_gap", 32'(bus.load_done), 32'h0);
    check("b2b_req1", 32'(bus.data_req), 32'h1);
    exp_q.push_back(32'h0000_0081);
    step();
    drive_idle(); #1;
    check("b2b_done1", 32'(bus.load_done), 32'h1);
    last_result = 32'h0000_0081;

    // Reset while waiting, then a late ack.
    step();
    bus.validM = 1'b1; bus.alucontrolM = `EXE_LW_OP; bus.aluoutM = 32'h70; #1;
    check("rw_stall", 32'(bus.stallM), 32'h1);
    step();
    resetn = 1'b0; bus.validM = 1'b0; #1;
    check("rw_req_in_reset", 32'(bus.data_req), 32'h0);
    check("rw_stall_in_reset", 32'(bus.stallM), 32'h0);
    step();
    resetn = 1'b1; drive_idle();
    bus.data_ack = 1'b1; bus.data_rdata = 32'h1111_1111; #1;
    check("rw_req", 32'(bus.data_req), 32'h0);
    check("rw_stall_after", 32'(bus.stallM), 32'h0);
    check("rw_adel", 32'(bus.adelM), 32'h0);
    check("rw_result", bus.readdata_resultM, 32'h0);
    step();
    bus.data_ack = 1'b0; #1;
    check("rw_no_done", 32'(bus.load_done), 32'h0);
    check("rw_result_held", bus.readdata_resultM, 32'h0);

    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
